if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//   Instruction-fetch stage directly downstream of the program counter register.
//   - Issues the current PC to instruction memory over a req/ack handshake; tolerates variable wait states.
//   - Captures the returned word into the IF/ID pipeline register.
//   - Drives PCWrite back to the PC register so the PC advances only when a fetch is delivered.
//   - Handles ID-stage stalls (one-entry skid buffer) and branch/jump flushes (discard in-flight fetch).
// PARAMETERS
//   INSTR_W  32            instruction word width
//   NOP      32'h00000000  word inserted into IF/ID on bubble/flush (sll $0,$0,0)
// PORTS
//   Clk          in   1   clock; all state updates on posedge
//   Reset        in   1   asynchronous, active-low reset (0 = reset)
//   PCResult     in   32  current PC from the program counter register
//   PCWrite      out  1   combinational; 1 = PC register loads PCNext this edge
//   IMemReq      out  1   fetch request to instruction memory
//   IMemAddr     out  32  fetch address; stable while IMemReq=1 and IMemAck=0
//   IMemAck      in   1   memory has IMemData valid this cycle (may assert in first req cycle)
//   IMemData     in   32  instruction word, valid when IMemAck=1
//   Stall        in   1   ID stage cannot accept; IF/ID holds
//   Flush        in   1   redirect (branch taken/jump); PCNext already holds target
//   IFID_Instr   out  32  registered instruction to ID
//   IFID_PCPlus4 out  32  registered PC+4 of that instruction (mod 2^32 wrap)
//   IFID_Valid   out  1   registered; 1 = IFID_Instr is a real fetched instruction
// BEHAVIOUR
//   Reset (Reset=0, async): state=FETCH, IMemReq=0 while in reset, IFID_Valid=0,
//     IFID_Instr=NOP, IFID_PCPlus4=0, skid buffer empty.
//     An abandoned in-flight memory request is the memory's problem (memory is reset too).
//   States: FETCH, BUFFERED, DRAIN.
//     IMemReq=1 in FETCH and DRAIN; 0 in BUFFERED.
//   Address:
//     - FETCH: IMemAddr=PCResult.
//     - DRAIN: IMemAddr=drain_addr, the PC latched on the Flush edge.
//   deliver = (FETCH & IMemAck) | (BUFFERED & ~Stall); data from IMemData or buffer respectively.
//   Priority per cycle: Flush > Stall > deliver.
//   FETCH:
//     - Flush & ~IMemAck: latch drain_addr=PCResult, ->DRAIN, PCWrite=1.
//     - Flush & IMemAck: discard word, stay FETCH, PCWrite=1.
//     - IMemAck & Stall: word+PC+4 -> buffer, ->BUFFERED, PCWrite=1 (PC already captured).
//     - IMemAck & ~Stall: IF/ID <= {word, PC+4, Valid=1}, PCWrite=1, stay FETCH.
//     - else: wait, PCWrite=0.
//   BUFFERED:
//     - Flush: drop buffer, ->FETCH, PCWrite=1.
//     - ~Stall: IF/ID <= buffer, ->FETCH, PCWrite=0.
//     - Stall: hold, PCWrite=0.
//   DRAIN:
//     - Stale request stays asserted on drain_addr until IMemAck; the word is discarded.
//     - On ack ->FETCH.
//     - Flush in DRAIN: PCWrite=1, stay DRAIN (drain_addr unchanged).
//     - PCWrite=Flush otherwise.
//   IF/ID register, evaluated each edge:
//     - Flush: Valid=0, Instr=NOP, PCPlus4 unchanged.
//     - else Stall: hold all fields.
//     - else deliver: load, Valid=1.
//     - else: bubble (Valid=0, Instr=NOP).
//   Throughput: zero-wait memory (IMemAck=1 in the first request cycle) gives 1 instruction/cycle.
//     Fetch-to-IF/ID latency is the ack edge.
//   A word is loaded into IF/ID or the buffer exactly once; never duplicated or lost under Stall.
// TESTING
//   1. Zero-wait mem, PC 0,4,8: IFID_Instr follows words on consecutive edges, PCPlus4=4,8,12, Valid=1 each cycle.
//   2. 2-wait mem at PC=0x10: IMemAddr=0x10 held 3 cycles, PCWrite=0 for 2 cycles then 1; IF/ID Valid=0 then word.
//   3. Ack at PC=0x20 with Stall held 3 cycles: buffered, IMemReq=0, IF/ID held; Stall drop -> word loaded once, PCPlus4=0x24.
//   4. Flush during 3-wait fetch at PC=0x40, target 0x100: IMemAddr stays 0x40 until ack; word discarded; next req 0x100.
//   5. Flush and IMemAck same cycle: IFID_Valid=0, Instr=NOP, PCWrite=1, next IMemAddr = target, no DRAIN.
//   6. Reset low mid-DRAIN and mid-BUFFERED: outputs at reset values; first fetch after release uses PCResult=0.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: issues PC to instruction memory over req/ack, fills the IF/ID
// register, and handles ID stalls with a one-entry skid buffer and flushes by draining the stale request.
module if_fetch_stage #(
    parameter int                 INSTR_W = 32,
    parameter logic [INSTR_W-1:0] NOP     = '0
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [31:0]        PCResult,
    output logic               PCWrite,
    output logic               IMemReq,
    output logic [31:0]        IMemAddr,
    input  logic               IMemAck,
    input  logic [INSTR_W-1:0] IMemData,
    input  logic               Stall,
    input  logic               Flush,
    output logic [INSTR_W-1:0] IFID_Instr,
    output logic [31:0]        IFID_PCPlus4,
    output logic               IFID_Valid
);

    typedef enum logic [1:0] {FETCH, BUFFERED, DRAIN} state_t;

    state_t             state;
    logic [31:0]        drain_addr;
    logic [INSTR_W-1:0] buf_instr;
    logic [31:0]        buf_pc4;

    logic               fetch_ack;
    logic               deliver;
    logic [INSTR_W-1:0] dlv_instr;
    logic [31:0]        dlv_pc4;

    assign fetch_ack = (state == FETCH) && IMemAck;
    assign deliver   = fetch_ack || ((state == BUFFERED) && !Stall);
    assign dlv_instr = (state == BUFFERED) ? buf_instr : IMemData;
    assign dlv_pc4   = (state == BUFFERED) ? buf_pc4 : PCResult + 32'd4;

    // Request is gated by Reset so memory sees no request while the stage is held in reset.
    assign IMemReq  = Reset && (state != BUFFERED);
    assign IMemAddr = (state == DRAIN) ? drain_addr : PCResult;
    // An acked fetch has consumed PCResult even if it lands in the buffer, so the PC may advance.
    assign PCWrite  = Flush || fetch_ack;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= FETCH;
            drain_addr <= '0;
            buf_instr  <= NOP;
            buf_pc4    <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (Flush) begin
                        if (!IMemAck) begin
                            drain_addr <= PCResult;
                            state      <= DRAIN;
                        end
                    end else if (IMemAck && Stall) begin
                        buf_instr <= IMemData;
                        buf_pc4   <= PCResult + 32'd4;
                        state     <= BUFFERED;
                    end
                end
                BUFFERED: begin
                    if (Flush || !Stall) state <= FETCH;
                end
                DRAIN: begin
                    if (IMemAck) state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            IFID_Instr   <= NOP;
            IFID_PCPlus4 <= '0;
            IFID_Valid   <= 1'b0;
        end else if (Flush) begin
            IFID_Instr <= NOP;
            IFID_Valid <= 1'b0;
        end else if (Stall) begin
            IFID_Instr   <= IFID_Instr;
            IFID_PCPlus4 <= IFID_PCPlus4;
            IFID_Valid   <= IFID_Valid;
        end else if (deliver) begin
            IFID_Instr   <= dlv_instr;
            IFID_PCPlus4 <= dlv_pc4;
            IFID_Valid   <= 1'b1;
        end else begin
            IFID_Instr <= NOP;
            IFID_Valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a PC register model and an address-tagged memory word
// surround the stage; ack/stall/flush are driven per cycle with hand-computed expectations.
module tb_if_fetch_stage;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] PCResult;
    logic        PCWrite;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemAck;
    logic [31:0] IMemData;
    logic        Stall;
    logic        Flush;
    logic [31:0] IFID_Instr;
    logic [31:0] IFID_PCPlus4;
    logic        IFID_Valid;

    logic [31:0] tgt;
    int          checks = 0;
    int          errors = 0;

    if_fetch_stage dut (
        .Clk(Clk), .Reset(Reset), .PCResult(PCResult), .PCWrite(PCWrite),
        .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemAck(IMemAck), .IMemData(IMemData),
        .Stall(Stall), .Flush(Flush), .IFID_Instr(IFID_Instr),
        .IFID_PCPlus4(IFID_PCPlus4), .IFID_Valid(IFID_Valid)
    );

    always #5 Clk = ~Clk;

    // Memory word carries its address so discarded/duplicated words are identifiable.
    assign IMemData = {16'hC0DE, IMemAddr[15:0]};

    always @(posedge Clk or negedge Reset) begin
        if (!Reset)       PCResult <= 32'd0;
        else if (PCWrite) PCResult <= Flush ? tgt : PCResult + 32'd4;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic ack, input logic stall, input logic flush);
        @(negedge Clk);
        IMemAck = ack; Stall = stall; Flush = flush;
        #1;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] instr,
                            input logic [31:0] pc4, input logic vld);
        chk({tag, ".instr"}, IFID_Instr, instr);
        chk({tag, ".pc4"}, IFID_PCPlus4, pc4);
        chk({tag, ".valid"}, {31'd0, IFID_Valid}, {31'd0, vld});
    endtask

    task automatic fast_fetch(input string tag);
        logic [31:0] pc;
        drive(1'b1, 1'b0, 1'b0);
        pc = PCResult;
        chk({tag, ".addr"}, IMemAddr, pc);
        chk({tag, ".pcw"}, {31'd0, PCWrite}, 32'd1);
        tick();
        chk_ifid(tag, {16'hC0DE, pc[15:0]}, pc + 32'd4, 1'b1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".req"}, {31'd0, IMemReq}, 32'd0);
        chk_ifid(tag, 32'd0, 32'd0, 1'b0);
    endtask

    initial begin
        Reset = 1'b0; IMemAck = 1'b0; Stall = 1'b0; Flush = 1'b0; tgt = 32'd0;
        #1;
        chk_reset("rst");
        repeat (2) @(posedge Clk);
        #1;
        chk_reset("rst_hold");
        @(negedge Clk);
        Reset = 1'b1;

        // 1: zero-wait memory, one instruction per cycle
        fast_fetch("t1_pc0");
        fast_fetch("t1_pc4");
        fast_fetch("t1_pc8");

        // 2: two wait states at 0x10
        fast_fetch("t2_pcC");
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b0);
            chk("t2_wait.addr", IMemAddr, 32'h10);
            chk("t2_wait.pcw", {31'd0, PCWrite}, 32'd0);
            tick();
            chk_ifid("t2_wait", 32'd0, 32'h10, 1'b0);
        end
        fast_fetch("t2_ack");
        chk("t2_pc", PCResult, 32'h14);

        // 3: ack at 0x20 under a 3-cycle stall
        for (int i = 0; i < 3; i++) fast_fetch("t3_pre");
        drive(1'b1, 1'b1, 1'b0);
        chk("t3_ack.addr", IMemAddr, 32'h20);
        chk("t3_ack.pcw", {31'd0, PCWrite}, 32'd1);
        tick();
        chk_ifid("t3_hold0", 32'hC0DE001C, 32'h20, 1'b1);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            chk("t3_buf.req", {31'd0, IMemReq}, 32'd0);
            chk("t3_buf.pcw", {31'd0, PCWrite}, 32'd0);
            tick();
            chk_ifid("t3_hold", 32'hC0DE001C, 32'h20, 1'b1);
        end
        drive(1'b0, 1'b0, 1'b0);
        chk("t3_rel.req", {31'd0, IMemReq}, 32'd0);
        chk("t3_rel.pcw", {31'd0, PCWrite}, 32'd0);
        tick();
        chk_ifid("t3_load", 32'hC0DE0020, 32'h24, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        chk("t3_next.req", {31'd0, IMemReq}, 32'd1);
        chk("t3_next.addr", IMemAddr, 32'h24);
        tick();
        chk_ifid("t3_once", 32'd0, 32'h24, 1'b0);

        // 4: flush during a 3-wait fetch at 0x40, target 0x100
        for (int i = 0; i < 7; i++) fast_fetch("t4_pre");
        tgt = 32'h100;
        drive(1'b0, 1'b0, 1'b1);
        chk("t4_fl.addr", IMemAddr, 32'h40);
        chk("t4_fl.pcw", {31'd0, PCWrite}, 32'd1);
        tick();
        chk_ifid("t4_fl", 32'd0, 32'h40, 1'b0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b0);
            chk("t4_drain.req", {31'd0, IMemReq}, 32'd1);
            chk("t4_drain.addr", IMemAddr, 32'h40);
            chk("t4_drain.pcw", {31'd0, PCWrite}, 32'd0);
            tick();
        end
        drive(1'b1, 1'b0, 1'b0);
        chk("t4_dack.addr", IMemAddr, 32'h40);
        chk("t4_dack.pcw", {31'd0, PCWrite}, 32'd0);
        tick();
        chk_ifid("t4_discard", 32'd0, 32'h40, 1'b0);
        fast_fetch("t4_tgt");
        chk("t4_pc", PCResult, 32'h104);

        // 5: flush and ack in the same cycle, target 0x200
        tgt = 32'h200;
        drive(1'b1, 1'b0, 1'b1);
        chk("t5.pcw", {31'd0, PCWrite}, 32'd1);
        tick();
        chk_ifid("t5", 32'd0, 32'h104, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        chk("t5_next.addr", IMemAddr, 32'h200);
        tick();
        chk_ifid("t5_next", 32'hC0DE0200, 32'h204, 1'b1);

        // 6a: reset while in DRAIN
        tgt = 32'h300;
        drive(1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        chk("t6a_drain.addr", IMemAddr, 32'h204);
        Reset = 1'b0;
        #1;
        chk_reset("t6a_rst");
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        chk("t6a_rel.addr", IMemAddr, 32'd0);
        chk("t6a_rel.req", {31'd0, IMemReq}, 32'd1);
        fast_fetch("t6a_first");

        // 6b: reset while BUFFERED
        drive(1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b1, 1'b0);
        chk("t6b_buf.req", {31'd0, IMemReq}, 32'd0);
        Reset = 1'b0;
        #1;
        chk_reset("t6b_rst");
        @(negedge Clk);
        Reset = 1'b1; Stall = 1'b0;
        #1;
        chk("t6b_rel.req", {31'd0, IMemReq}, 32'd1);
        chk("t6b_rel.addr", IMemAddr, 32'd0);
        tick();
        chk_ifid("t6b_empty", 32'd0, 32'd0, 1'b0);
        fast_fetch("t6b_first");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
